// File: rtl/preamble_tx_seq.sv
// 802.11a/g OFDM preamble transmit sequencer. It walks the short ROM and then the
// long ROM, and presents registered samples on a valid/ready stream.
module preamble_tx_seq #(
    parameter int SHORT_REPS = 10,
    parameter int WINDOW     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               skip_short,
    input  logic               abort,
    output logic [3:0]         sp_addr,
    input  logic signed [15:0] sp_i,
    input  logic signed [15:0] sp_q,
    output logic [7:0]         lp_addr,
    input  logic signed [15:0] lp_i,
    input  logic signed [15:0] lp_q,
    output logic signed [15:0] sample_i,
    output logic signed [15:0] sample_q,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               sample_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, SHORT, LONG, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } iq_t;

    localparam logic [7:0] SHORT_END = 8'(SHORT_REPS * 16 - 1);
    localparam logic [7:0] LONG_END  = 8'd159;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       first, first_n;
    iq_t        smp, smp_n, src, src_w;
    logic       valid_n, last_n, busy_n, done_n;
    logic       adv, accept;

    assign adv    = enable && (!sample_valid || sample_ready);
    assign accept = sample_valid && sample_ready;

    assign sp_addr  = (state == SHORT) ? cnt[3:0] : 4'd0;
    assign lp_addr  = (state == LONG)  ? cnt      : 8'd0;
    assign sample_i = smp.i;
    assign sample_q = smp.q;

    // The first sample of a packet is halved to soften the burst edge.
    always_comb begin
        src   = (state == LONG) ? {lp_i, lp_q} : {sp_i, sp_q};
        src_w = src;
        if (WINDOW != 0 && first) begin
            src_w.i = {src.i[15], src.i[15:1]};
            src_w.q = {src.q[15], src.q[15:1]};
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        first_n = first;
        smp_n   = smp;
        valid_n = sample_valid;
        last_n  = sample_last;
        busy_n  = busy;
        done_n  = 1'b0;

        if (accept) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_n   = '0;
                    first_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = skip_short ? LONG : SHORT;
                end
            end
            SHORT: begin
                if (adv) begin
                    smp_n   = src_w;
                    valid_n = 1'b1;
                    first_n = 1'b0;
                    cnt_n   = cnt + 8'd1;
                    if (cnt == SHORT_END) begin
                        cnt_n   = '0;
                        state_n = LONG;
                    end
                end
            end
            LONG: begin
                if (adv) begin
                    smp_n   = src_w;
                    valid_n = 1'b1;
                    first_n = 1'b0;
                    cnt_n   = cnt + 8'd1;
                    last_n  = (cnt == LONG_END);
                    if (cnt == LONG_END)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // abort beats start and any pending load; done is suppressed
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            first_n = 1'b0;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            first        <= 1'b0;
            smp          <= '0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (enable) begin
            state        <= state_n;
            cnt          <= cnt_n;
            first        <= first_n;
            smp          <= smp_n;
            sample_valid <= valid_n;
            sample_last  <= last_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_preamble_tx_seq.sv
// Directed bench for preamble_tx_seq: ROM models driven from the DUT addresses,
// stream capture against a reference sample model, plus control corner cases.
module tb_preamble_tx_seq;

    logic        clock = 0;
    logic        reset, enable, start, skip_short, abort;
    logic [3:0]  sp_addr;
    logic [7:0]  lp_addr;
    logic [15:0] sp_i, sp_q, lp_i, lp_q;
    logic [15:0] sample_i, sample_q;
    logic        sample_valid, sample_ready, sample_last, busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int got, errs, first_cyc, done_cyc, start_edge;
    logic [31:0] cap [0:399];
    logic [31:0] ref0 [0:319];

    preamble_tx_seq #(.SHORT_REPS(10), .WINDOW(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .skip_short(skip_short), .abort(abort),
        .sp_addr(sp_addr), .sp_i(sp_i), .sp_q(sp_q),
        .lp_addr(lp_addr), .lp_i(lp_i), .lp_q(lp_q),
        .sample_i(sample_i), .sample_q(sample_q), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_last(sample_last),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] sp_rom(input logic [3:0] a);
        int ai = int'(a);
        if (a == 4'd0) return 32'hF3A5_0BC5;
        return {16'(32'h0123 * ai), 16'(32'hF000 + 32'h0051 * ai)};
    endfunction

    function automatic logic [31:0] lp_rom(input logic [7:0] a);
        int ai = int'(a);
        case (a)
            8'd0:    return 32'h0000_EC00;
            8'd32:   return 32'h0000_1400;
            8'd159:  return 32'h0F67_FF58;
            default: return {16'(32'h2000 + ai * 7), 16'(32'h8000 ^ (ai * 13))};
        endcase
    endfunction

    assign {sp_i, sp_q} = sp_rom(sp_addr);
    assign {lp_i, lp_q} = lp_rom(lp_addr);

    // Reference stream: index k of a packet, halving only the first sample.
    function automatic logic [31:0] exp_sample(input int k, input bit skip);
        logic [31:0] r;
        if (!skip && k < 160) r = sp_rom(4'(k % 16));
        else                  r = lp_rom(8'(skip ? k : k - 160));
        if (k == 0) r = {r[31], r[31:17], r[15], r[15:1]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input bit skip);
        skip_short = skip;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        skip_short = 1'b0;
        start_edge = cyc;
    endtask

    // Consume a packet until done (or abort point), checking every accepted
    // sample against the model and that stalled samples hold.
    task automatic stream(input int n_exp, input bit skip, input bit rnd,
                          input int abort_at, input int en_at, input int dup_at);
        logic [32:0] held;
        logic [44:0] snap;
        bit stalled = 0, en_done = 0, dup_done = 0;
        got = 0; errs = 0; first_cyc = -1; done_cyc = -1;
        for (int c = 0; c < 4000; c++) begin
            if (!en_done && got == en_at) begin
                snap = {sample_i, sample_q, sample_valid, lp_addr, sp_addr};
                enable = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    if ({sample_i, sample_q, sample_valid, lp_addr, sp_addr} !== snap) errs++;
                end
                enable  = 1'b1;
                en_done = 1;
            end
            start = (!dup_done && got == dup_at);
            if (start) dup_done = 1;
            sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && {sample_i, sample_q, sample_last} !== held) errs++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (sample_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (got == abort_at) begin
                    abort        = 1'b1;
                    sample_ready = 1'b0;
                    @(negedge clock);
                    abort = 1'b0;
                    break;
                end
                if (sample_ready) begin
                    if (got < 400) cap[got] = {sample_i, sample_q};
                    if ({sample_i, sample_q} !== exp_sample(got, skip) ||
                        sample_last !== (got == n_exp - 1)) errs++;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = {sample_i, sample_q, sample_last};
                end
            end else begin
                stalled = 0;
            end
            @(negedge clock);
        end
        start        = 1'b0;
        sample_ready = 1'b1;
    endtask

    initial begin
        int diffs;
        bit dseen;
        reset = 1; enable = 1; start = 0; skip_short = 0; abort = 0; sample_ready = 1;
        repeat (3) @(negedge clock);
        check("reset_outputs", {sample_i, sample_q, sample_valid, sample_last, busy, done, sp_addr, lp_addr}, 0);
        reset = 0;

        // Full preamble with ready held high, start sampled at edge 10
        while (cyc < 9) @(negedge clock);
        do_start(0);
        check("busy_after_start", busy, 1);
        stream(320, 0, 0, -1, -1, -1);
        check("full_first_latency", first_cyc - start_edge, 1);
        check("full_count", got, 320);
        check("full_stream_errs", errs, 0);
        check("full_sample0", cap[0], 32'hF9D2_05E2);
        check("full_sample160", cap[160], 32'h0000_EC00);
        check("full_sample319", cap[319], 32'h0F67_FF58);
        check("full_done_cycle", done_cyc, 331);
        for (int k = 0; k < 320; k++) ref0[k] = cap[k];
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("busy_low_after_done", busy, 0);

        // Long preamble only
        do_start(1);
        stream(160, 1, 0, -1, -1, -1);
        check("skip_count", got, 160);
        check("skip_stream_errs", errs, 0);
        check("skip_sample0", cap[0], 32'h0000_F600);
        check("skip_sample32", cap[32], 32'h0000_1400);
        check("skip_sample159", cap[159], 32'h0F67_FF58);
        @(negedge clock);

        // Random backpressure must give the identical stream
        do_start(0);
        stream(320, 0, 1, -1, -1, -1);
        check("rnd_count", got, 320);
        check("rnd_stream_errs", errs, 0);
        check("rnd_done_seen", done_cyc >= 0, 1);
        diffs = 0;
        for (int k = 0; k < 320; k++) if (cap[k] !== ref0[k]) diffs++;
        check("rnd_vs_ready1", diffs, 0);
        @(negedge clock);

        // Abort at sample 200, then a clean restart
        do_start(0);
        stream(320, 0, 0, 200, -1, -1);
        check("abort_count", got, 200);
        check("abort_valid_busy_last", {sample_valid, busy, sample_last}, 0);
        dseen = 0;
        repeat (20) begin
            dseen |= done;
            @(negedge clock);
        end
        check("abort_no_done", dseen, 0);
        do_start(0);
        check("restart_sp_addr", sp_addr, 0);
        stream(320, 0, 0, -1, -1, -1);
        check("restart_count", got, 320);
        check("restart_stream_errs", errs, 0);
        @(negedge clock);

        // enable low for 5 cycles mid-LONG, then a held done pulse
        do_start(0);
        stream(320, 0, 0, -1, 250, -1);
        check("freeze_count", got, 320);
        check("freeze_stream_errs", errs, 0);
        check("freeze_done_cycle", done_cyc - start_edge, 326);
        enable = 1'b0;
        @(negedge clock);
        check("done_held_by_enable", done, 1);
        enable = 1'b1;
        @(negedge clock);
        check("done_released", done, 0);

        // start while busy is ignored
        do_start(0);
        stream(320, 0, 0, -1, -1, 50);
        check("dup_start_count", got, 320);
        check("dup_start_errs", errs, 0);
        @(negedge clock);

        // Reset mid-SHORT, then a normal packet
        do_start(0);
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_outputs", {sample_i, sample_q, sample_valid, sample_last, busy, done, sp_addr, lp_addr}, 0);
        reset = 1'b0;
        @(negedge clock);
        do_start(0);
        check("post_reset_sp_addr", sp_addr, 0);
        stream(320, 0, 0, -1, -1, -1);
        check("post_reset_latency", first_cyc - start_edge, 1);
        check("post_reset_count", got, 320);
        check("post_reset_errs", errs, 0);
        check("post_reset_done", done_cyc - start_edge, 321);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
